proc_ctrl_fsm: RTL and testbench

Instruction sequencer for the enhanced processor: a Moore/Mealy FSM that fetches each instruction from memory, loads the IR, and drives the bus-select, register-enable, ALU and memory-interface strobes for one execute step per clock. Register write enables come from the 3-to-8 decode of rX, so exactly one `R_in` bit is set per write. The block sits between the IR/flag registers and the datapath bus mux.

---
 rtl/proc_ctrl_fsm.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : proc_ctrl_fsm
// Brief    : T0-T5 instruction sequencer for the enhanced processor. Fetches,
//            loads IR and drives bus-select, register-load, ALU and memory
//            strobes. Optional macro PROC_CTRL_BRANCH_EN enables b{cond}.
// Revision : 1.0
// ============================================================================
module proc_ctrl_fsm (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic [15:0] IR,
    input  logic        Z,
    input  logic        N,
    input  logic        C,
    output logic [3:0]  Sel,
    output logic [0:7]  R_in,
    output logic        IR_in,
    output logic        A_in,
    output logic        G_in,
    output logic        F_in,
    output logic [1:0]  ALU_op,
    output logic        ADDR_in,
    output logic        DOUT_in,
    output logic        W_D,
    output logic        pc_incr,
    output logic        Done
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_B   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    localparam logic [3:0] SEL_PC   = 4'd7;
    localparam logic [3:0] SEL_DIN  = 4'd8;
    localparam logic [3:0] SEL_G    = 4'd9;
    localparam logic [3:0] SEL_IMM  = 4'd10;
    localparam logic [3:0] SEL_HIGH = 4'd11;

    state_t      state_q;
    state_t      state_d;

    logic [2:0]  opcode;
    logic        imm_m;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [3:0]  sel_rx;
    logic [3:0]  sel_ry;
    logic [3:0]  sel_src;
    logic [0:7]  rx_onehot;
    logic [0:7]  pc_onehot;
    logic [1:0]  alu_code;

    assign opcode  = IR[15:13];
    assign imm_m   = IR[12];
    assign rx      = IR[11:9];
    assign ry      = IR[2:0];
    assign sel_rx  = {1'b0, rx};
    assign sel_ry  = {1'b0, ry};
    assign sel_src = imm_m ? SEL_IMM : sel_ry;

    // imm9 feeds the datapath directly; only the register fields matter here.
    logic unused_ir;
    assign unused_ir = ^IR[8:3];

    always_comb begin
        rx_onehot     = '0;
        rx_onehot[rx] = 1'b1;
        pc_onehot     = '0;
        pc_onehot[7]  = 1'b1;
    end

    always_comb begin
        alu_code = ALU_ADD;
        case (opcode)
            OP_SUB:  alu_code = ALU_SUB;
            OP_AND:  alu_code = ALU_AND;
            default: alu_code = ALU_ADD;
        endcase
    end

`ifdef PROC_CTRL_BRANCH_EN
    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (rx)
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = Z;
            3'b010:  br_taken = ~Z;
            3'b011:  br_taken = ~C;
            3'b100:  br_taken = C;
            3'b101:  br_taken = ~N;
            3'b110:  br_taken = N;
            default: br_taken = 1'b0;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = Z ^ N ^ C;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        Sel     = 4'd0;
        R_in    = '0;
        IR_in   = 1'b0;
        A_in    = 1'b0;
        G_in    = 1'b0;
        F_in    = 1'b0;
        ALU_op  = ALU_ADD;
        ADDR_in = 1'b0;
        DOUT_in = 1'b0;
        W_D     = 1'b0;
        pc_incr = 1'b0;
        Done    = 1'b0;

        // Reset silences every strobe so an aborted instruction writes nothing.
        if (Reset) begin
            state_d = T0;
        end else begin
            case (state_q)
                T0: begin
                    if (Run) begin
                        Sel     = SEL_PC;
                        ADDR_in = 1'b1;
                        pc_incr = 1'b1;
                        state_d = T1;
                    end
                end

                T1: begin
                    state_d = T2;
                end

                T2: begin
                    IR_in   = 1'b1;
                    state_d = T3;
                end

                T3: begin
                    case (opcode)
                        OP_MV: begin
                            Sel     = sel_src;
                            R_in    = rx_onehot;
                            Done    = 1'b1;
                            state_d = T0;
                        end
                        OP_MVT: begin
                            Sel     = SEL_HIGH;
                            R_in    = rx_onehot;
                            Done    = 1'b1;
                            state_d = T0;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            Sel     = sel_rx;
                            A_in    = 1'b1;
                            state_d = T4;
                        end
                        OP_LD, OP_ST: begin
                            Sel     = sel_ry;
                            ADDR_in = 1'b1;
                            state_d = T4;
                        end
                        default: begin
`ifdef PROC_CTRL_BRANCH_EN
                            if (br_taken) begin
                                Sel     = SEL_PC;
                                A_in    = 1'b1;
                                state_d = T4;
                            end else begin
                                Done    = 1'b1;
                                state_d = T0;
                            end
`else
                            Done    = 1'b1;
                            state_d = T0;
`endif
                        end
                    endcase
                end

                T4: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND: begin
                            Sel     = sel_src;
                            G_in    = 1'b1;
                            F_in    = 1'b1;
                            ALU_op  = alu_code;
                            state_d = T5;
                        end
                        OP_LD: begin
                            state_d = T5;
                        end
                        OP_ST: begin
                            Sel     = sel_rx;
                            DOUT_in = 1'b1;
                            W_D     = 1'b1;
                            Done    = 1'b1;
                            state_d = T0;
                        end
`ifdef PROC_CTRL_BRANCH_EN
                        OP_B: begin
                            // Only a taken branch reaches T4: G = PC + offset.
                            Sel     = SEL_IMM;
                            G_in    = 1'b1;
                            ALU_op  = ALU_ADD;
                            state_d = T5;
                        end
`endif
                        default: begin
                            state_d = T0;
                        end
                    endcase
                end

                T5: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND: begin
                            Sel     = SEL_G;
                            R_in    = rx_onehot;
                            Done    = 1'b1;
                        end
                        OP_LD: begin
                            Sel     = SEL_DIN;
                            R_in    = rx_onehot;
                            Done    = 1'b1;
                        end
`ifdef PROC_CTRL_BRANCH_EN
                        OP_B: begin
                            Sel     = SEL_G;
                            R_in    = pc_onehot;
                            Done    = 1'b1;
                        end
`endif
                        default: begin
                            Done    = 1'b0;
                        end
                    endcase
                    state_d = T0;
                end

                default: begin
                    state_d = T0;
                end
            endcase
        end
    end

    // PC increment (T0) and R_in[7] (T3/T5) can never coincide by construction.
    logic unused_pc;
    assign unused_pc = pc_onehot[0] ^ OP_MV[0] ^ OP_MVT[0];

endmodule
`default_nettype wire

// File: tb/tb_proc_ctrl_fsm.sv
`default_nettype none
// Scoreboard bench for proc_ctrl_fsm: an instruction-level model produces the
// expected per-cycle control vector; a negedge monitor compares the DUT.
module tb_proc_ctrl_fsm;

    logic        Clock = 1'b1;
    logic        Reset;
    logic        Run;
    logic [15:0] IR;
    logic        Z, N, C;
    logic [3:0]  Sel;
    logic [0:7]  R_in;
    logic        IR_in, A_in, G_in, F_in;
    logic [1:0]  ALU_op;
    logic        ADDR_in, DOUT_in, W_D, pc_incr, Done;

    typedef logic [22:0] vec_t;

    vec_t exp_q[$];
    vec_t seq[$];
    vec_t act;
    int   checks   = 0;
    int   failures = 0;
    int   cycle_no = 0;

    proc_ctrl_fsm dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Run     (Run),
        .IR      (IR),
        .Z       (Z),
        .N       (N),
        .C       (C),
        .Sel     (Sel),
        .R_in    (R_in),
        .IR_in   (IR_in),
        .A_in    (A_in),
        .G_in    (G_in),
        .F_in    (F_in),
        .ALU_op  (ALU_op),
        .ADDR_in (ADDR_in),
        .DOUT_in (DOUT_in),
        .W_D     (W_D),
        .pc_incr (pc_incr),
        .Done    (Done)
    );

    always #5 Clock = ~Clock;

    assign act = {Sel, R_in, IR_in, A_in, G_in, F_in, ALU_op,
                  ADDR_in, DOUT_in, W_D, pc_incr, Done};

    function automatic vec_t mk(input logic [3:0] sel, input logic [0:7] rin,
                                input logic irin, input logic ain, input logic gin,
                                input logic fin, input logic [1:0] alu,
                                input logic addr, input logic dout, input logic wd,
                                input logic pcinc, input logic done);
        return {sel, rin, irin, ain, gin, fin, alu, addr, dout, wd, pcinc, done};
    endfunction

    function automatic logic [0:7] oh(input logic [2:0] r);
        logic [0:7] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic cond_holds(input logic [2:0] cond, input logic z,
                                        input logic n, input logic c);
        case (cond)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return !c;
            3'd4:    return c;
            3'd5:    return !n;
            3'd6:    return n;
            default: return 1'b0;
        endcase
    endfunction

    // Expected cycle-by-cycle strobes of one instruction, T0 (Run=1) to Done.
    function automatic void build_seq(input logic [15:0] ir, input logic z,
                                      input logic n, input logic c);
        logic [2:0] op, rx, ry;
        logic [3:0] src;
        logic       taken;
        op  = ir[15:13];
        rx  = ir[11:9];
        ry  = ir[2:0];
        src = ir[12] ? 4'd10 : {1'b0, ry};
        seq.delete();
        seq.push_back(mk(4'd7, 8'h00, 0, 0, 0, 0, 2'd0, 1, 0, 0, 1, 0));
        seq.push_back('0);
        seq.push_back(mk(4'd0, 8'h00, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0));
        case (op)
            3'd0: seq.push_back(mk(src,   oh(rx), 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
            3'd1: seq.push_back(mk(4'd11, oh(rx), 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
            3'd2, 3'd3, 3'd6: begin
                seq.push_back(mk({1'b0, rx}, 8'h00, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0));
                seq.push_back(mk(src, 8'h00, 0, 0, 1, 1,
                                 (op == 3'd2) ? 2'd0 : (op == 3'd3) ? 2'd1 : 2'd2,
                                 0, 0, 0, 0, 0));
                seq.push_back(mk(4'd9, oh(rx), 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
            end
            3'd4: begin
                seq.push_back(mk({1'b0, ry}, 8'h00, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 0));
                seq.push_back('0);
                seq.push_back(mk(4'd8, oh(rx), 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
            end
            3'd5: begin
                seq.push_back(mk({1'b0, ry}, 8'h00, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 0));
                seq.push_back(mk({1'b0, rx}, 8'h00, 0, 0, 0, 0, 2'd0, 0, 1, 1, 0, 1));
            end
            default: begin
`ifdef PROC_CTRL_BRANCH_EN
                taken = cond_holds(rx, z, n, c);
`else
                taken = 1'b0;
`endif
                if (taken) begin
                    seq.push_back(mk(4'd7,  8'h00, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0));
                    seq.push_back(mk(4'd10, 8'h00, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0));
                    seq.push_back(mk(4'd9,  oh(3'd7), 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
                end else begin
                    seq.push_back(mk(4'd0, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
                end
            end
        endcase
    endfunction

    task automatic drive(input logic run, input logic rst, input vec_t e);
        Run   = run;
        Reset = rst;
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic z, input logic n,
                             input logic c, input int idle, input int abort_at);
        IR = ir;
        Z  = z;
        N  = n;
        C  = c;
        for (int k = 0; k < idle; k++) drive(1'b0, 1'b0, '0);
        build_seq(ir, z, n, c);
        for (int i = 0; i < seq.size(); i++) begin
            if (i == abort_at) begin
                drive(1'b1, 1'b1, '0);
                break;
            end
            drive((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, seq[i]);
        end
    endtask

    always @(negedge Clock) begin
        cycle_no++;
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL ctrl_vec cycle=%0d IR=%h actual=%h required=%h",
                         cycle_no, IR, act, e);
            end
        end
    end

    initial begin
        IR = 16'h0000;
        Z  = 1'b0;
        N  = 1'b0;
        C  = 1'b0;
        drive(1'b1, 1'b1, '0);
        drive(1'b0, 1'b1, '0);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, '0);

        run_instr(16'h1205, 0, 0, 0, 0, -1);
        run_instr(16'h6403, 0, 0, 0, 0, -1);
        run_instr(16'hA004, 0, 0, 0, 1, -1);
        run_instr(16'hE3FE, 0, 0, 0, 0, -1);
        run_instr(16'hE3FE, 1, 0, 0, 0, -1);
        run_instr(16'h8605, 0, 0, 0, 0, 4);
        run_instr(16'h1205, 0, 0, 0, 0, -1);
        run_instr(16'h2A7F, 0, 1, 1, 0, -1);
        run_instr(16'h4E07, 1, 1, 1, 0, -1);

        for (int t = 0; t < 300; t++) begin
            logic [15:0] r_ir;
            int          abort;
            r_ir  = 16'($urandom);
            abort = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_instr(r_ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), abort);
        end

        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        @(negedge Clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
